// File: rtl/seq_booth_mac.sv
// Iterative radix-4 Booth multiply-accumulate: one Booth digit per cycle, valid/ready on both sides.
// Define SEQ_BOOTH_MAC_SAT_EN for a saturating accumulator with sticky acc_sat; otherwise acc wraps.
module seq_booth_mac #(
    parameter int W     = 16,
    parameter int ACC_W = 2*W+8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       a,
    input  logic [W-1:0]       b,
    input  logic               is_signed,
    input  logic               acc_en,
    input  logic               acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*W-1:0]     product,
    output logic [ACC_W-1:0]   acc,
    output logic               acc_sat,
    output logic               busy
);

    localparam int PW = 2*W+4;
    localparam int CW = $clog2(W/2+1);
    localparam logic [CW-1:0] LAST = CW'(W/2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q;
    logic signed [PW-1:0]    mcand_q;
    logic [W+2:0]            mplr_q;
    logic signed [PW-1:0]    pacc_q, pacc_nxt;
    logic                    sgn_q, acc_en_q;
    logic [2*W-1:0]          product_q;
    logic [ACC_W-1:0]        acc_q, acc_base;
    logic                    sat_q;
    logic                    last_digit, acc_upd;
    logic [ACC_W:0]          acc_res;
    logic [W+1:0]            a_x;

    // Radix-4 Booth recoding of one digit {b[2k+1], b[2k], b[2k-1]} into {0, +-1, +-2} x multiplicand.
    function automatic logic signed [PW-1:0] booth_term(input logic [2:0] dig,
                                                       input logic signed [PW-1:0] m);
        case (dig)
            3'b001, 3'b010: return m;
            3'b011:         return m <<< 1;
            3'b100:         return -(m <<< 1);
            3'b101, 3'b110: return -m;
            default:        return '0;
        endcase
    endfunction

    // Returns {clamped, new_acc} for base + ext(p).
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] base,
                                               input logic [2*W-1:0]   p,
                                               input logic             sgn);
        logic [ACC_W+2*W-1:0] wide;
        logic [ACC_W-1:0]     ext;
`ifdef SEQ_BOOTH_MAC_SAT_EN
        logic [ACC_W:0]       sum;
        logic                 ovf;
        logic [ACC_W-1:0]     clamp;
        wide = {{ACC_W{sgn & p[2*W-1]}}, p};
        ext  = wide[ACC_W-1:0];
        sum  = {1'b0, base} + {1'b0, ext};
        if (sgn) begin
            ovf   = (base[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
            clamp = base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            ovf   = sum[ACC_W];
            clamp = {ACC_W{1'b1}};
        end
        return ovf ? {1'b1, clamp} : {1'b0, sum[ACC_W-1:0]};
`else
        wide = {{ACC_W{sgn & p[2*W-1]}}, p};
        ext  = wide[ACC_W-1:0];
        return {1'b0, base + ext};
`endif
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_x        = {{2{is_signed & a[W-1]}}, a};
        pacc_nxt   = pacc_q + booth_term(mplr_q[2:0], mcand_q);
        last_digit = (state_q == RUN) && (cnt_q == LAST);
        acc_upd    = last_digit && acc_en_q;
        acc_base   = acc_clr ? '0 : acc_q;
        acc_res    = acc_add(acc_base, pacc_nxt[2*W-1:0], sgn_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            product_q <= '0;
            acc_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (in_valid) begin
                    mcand_q  <= signed'({{(W+2){a_x[W+1]}}, a_x});
                    mplr_q   <= {{2{is_signed & b[W-1]}}, b, 1'b0};
                    pacc_q   <= '0;
                    cnt_q    <= '0;
                    sgn_q    <= is_signed;
                    acc_en_q <= acc_en;
                end
                RUN: begin
                    pacc_q  <= pacc_nxt;
                    mcand_q <= mcand_q <<< 2;
                    mplr_q  <= mplr_q >> 2;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_digit) product_q <= pacc_nxt[2*W-1:0];
                end
                default: ;
            endcase
            // Clear takes effect before a coincident accumulate.
            if (acc_upd) begin
                acc_q <= acc_res[ACC_W-1:0];
                sat_q <= (sat_q & ~acc_clr) | acc_res[ACC_W];
            end else if (acc_clr) begin
                acc_q <= '0;
                sat_q <= 1'b0;
            end
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign product   = product_q;
    assign acc       = acc_q;
    assign acc_sat   = sat_q;

endmodule

// File: tb/tb_seq_booth_mac.sv
// Directed bench for seq_booth_mac: a W=16/ACC_W=40 instance plus an ACC_W=32 instance for overflow.
module tb_seq_booth_mac;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst, in_valid, is_signed, acc_en, acc_clr, out_ready;
    logic [W-1:0] a, b;

    logic        in_ready, out_valid, acc_sat, busy;
    logic [31:0] product;
    logic [39:0] acc;

    logic        in_ready2, out_valid2, acc_sat2, busy2;
    logic [31:0] product2;
    logic [31:0] acc2;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    seq_booth_mac #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .product(product),
        .acc(acc), .acc_sat(acc_sat), .busy(busy)
    );

    seq_booth_mac #(.W(W), .ACC_W(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .is_signed(is_signed), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid2), .out_ready(out_ready), .product(product2),
        .acc(acc2), .acc_sat(acc_sat2), .busy(busy2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Stimulus helpers: all start and end just after a falling edge.
    task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic s, input logic e);
        a = ia; b = ib; is_signed = s; acc_en = e; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 40);
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (product !== 32'h0) begin fails++; $display("FAIL reset_product: got %h want 0", product); end
        tests++; if (acc !== 40'h0) begin fails++; $display("FAIL reset_acc: got %h want 0", acc); end
        tests++; if (acc_sat !== 1'b0) begin fails++; $display("FAIL reset_acc_sat: got %b want 0", acc_sat); end
        rst = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        int n;
        issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL unsigned_busy: got %b want 1", busy); end
        wait_done(n);
        tests++; if (n != 9) begin fails++; $display("FAIL unsigned_latency: got %0d want 9", n); end
        tests++; if (product !== 32'hFFFE0001) begin fails++; $display("FAIL unsigned_product: got %h want fffe0001", product); end
        retire();
    endtask

    task automatic test_signed();
        logic [15:0] va [3] = '{16'h8000, 16'hFFFF, 16'hFFFE};
        logic [15:0] vb [3] = '{16'h8000, 16'hFFFF, 16'h0003};
        logic [31:0] vp [3] = '{32'h40000000, 32'h00000001, 32'hFFFFFFFA};
        int n;
        for (int i = 0; i < 3; i++) begin
            issue(va[i], vb[i], 1'b1, 1'b0);
            wait_done(n);
            tests++; if (product !== vp[i]) begin fails++; $display("FAIL signed_product_%0d: got %h want %h", i, product, vp[i]); end
            retire();
        end
    endtask

    task automatic test_accumulate();
        int n;
        issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        wait_done(n);
        tests++; if (acc !== 40'h00FFFE0001) begin fails++; $display("FAIL acc_first: got %h want 00fffe0001", acc); end
        retire();
        issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        wait_done(n);
        tests++; if (acc !== 40'h01FFFC0002) begin fails++; $display("FAIL acc_second: got %h want 01fffc0002", acc); end
        retire();
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        tests++; if (acc !== 40'h0) begin fails++; $display("FAIL acc_clear: got %h want 0", acc); end
        issue(16'hFFFE, 16'h0003, 1'b1, 1'b1);
        wait_done(n);
        tests++; if (acc !== 40'hFFFFFFFFFA) begin fails++; $display("FAIL acc_signed: got %h want fffffffffa", acc); end
        retire();
        // Clear landing on the accumulate edge: result is 0 + product.
        issue(16'h0002, 16'h0003, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL acc_clr_coinc_valid: got %b want 1", out_valid); end
        tests++; if (acc !== 40'h6) begin fails++; $display("FAIL acc_clr_coinc: got %h want 6", acc); end
        retire();
    endtask

    task automatic test_backpressure();
        int n;
        issue(16'h0005, 16'h0007, 1'b0, 1'b0);
        wait_done(n);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a = 16'(i * 16'h1111);
            @(negedge clk);
            tests++; if (out_valid !== 1'b1 || product !== 32'd35 || in_ready !== 1'b0)
                begin fails++; $display("FAIL backpressure_%0d: got v=%b p=%h r=%b want v=1 p=23 r=0", i, out_valid, product, in_ready); end
        end
        out_ready = 1'b1; in_valid = 1'b1; a = 16'h0003; b = 16'h0004;
        @(negedge clk);
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin fails++; $display("FAIL backpressure_release: got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(n);
        tests++; if (n != 9 || product !== 32'd12)
            begin fails++; $display("FAIL backpressure_resume: got lat=%0d p=%h want lat=9 p=c", n, product); end
        retire();
    endtask

    task automatic test_back_to_back();
        int n, t1, t2;
        a = 16'd9; b = 16'd9; is_signed = 1'b0; acc_en = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        wait_done(n);
        t1 = cyc;
        @(negedge clk);
        wait_done(n);
        t2 = cyc;
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        tests++; if (t2 - t1 != 11) begin fails++; $display("FAIL back_to_back_period: got %0d want 11", t2 - t1); end
        tests++; if (product !== 32'd81) begin fails++; $display("FAIL back_to_back_product: got %h want 51", product); end
    endtask

    task automatic test_overflow();
        int n;
        logic [31:0] exp_acc;
        logic        exp_sat;
`ifdef SEQ_BOOTH_MAC_SAT_EN
        exp_acc = 32'h7FFFFFFF; exp_sat = 1'b1;
`else
        exp_acc = 32'hBFFD0003; exp_sat = 1'b0;
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(16'h7FFF, 16'h7FFF, 1'b1, 1'b1);
            wait_done(n);
            retire();
        end
        tests++; if (acc2 !== exp_acc) begin fails++; $display("FAIL overflow_acc32: got %h want %h", acc2, exp_acc); end
        tests++; if (acc_sat2 !== exp_sat) begin fails++; $display("FAIL overflow_sat32: got %b want %b", acc_sat2, exp_sat); end
        tests++; if (acc !== 40'h00BFFD0003 || acc_sat !== 1'b0)
            begin fails++; $display("FAIL overflow_acc40: got %h sat=%b want 00bffd0003 sat=0", acc, acc_sat); end
    endtask

    task automatic test_reset_mid_run();
        logic seen;
        issue(16'h1234, 16'h5678, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++; if (out_valid !== 1'b0 || acc !== 40'h0 || busy !== 1'b0 || in_ready !== 1'b0)
            begin fails++; $display("FAIL midrun_reset: got v=%b acc=%h busy=%b r=%b want 0 0 0 0", out_valid, acc, busy, in_ready); end
        rst = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrun_in_ready: got %b want 1", in_ready); end
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL midrun_stale_result: got %b want 0", seen); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; is_signed = 1'b0; acc_en = 1'b0;
        acc_clr = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        @(negedge clk);
        test_reset();
        test_unsigned();
        test_signed();
        test_accumulate();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
